// File: rtl/sha1_pkg.sv
// sha1_pkg: shared state type and widths for the SHA-1 block feeder
package sha1_pkg;
    localparam int BLOCK_W = 512;
    localparam int DIGEST_W = 160;
    localparam int WORD_W = 32;
    localparam int WORDS = BLOCK_W / WORD_W;
    localparam logic [7:0] PAD_MARKER = 8'h80;
    localparam logic [3:0] LEN_HI_IDX = 4'd14;
    localparam logic [3:0] LEN_LO_IDX = 4'd15;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        PAD = 3'd2,
        ISSUE = 3'd3,
        WAIT_CORE = 3'd4,
        DONE = 3'd5
    } state_e;
endpackage

// File: rtl/sha1_block_feeder_if.sv
// sha1_block_feeder_if: message input, SHA-1 core and digest handshakes of the feeder
// slave: the feeder itself; master: the message source, core and digest consumer
interface sha1_block_feeder_if;
    import sha1_pkg::*;
    logic                in_valid;
    logic                in_ready;
    logic [WORD_W-1:0]   in_data;
    logic                in_last;
    logic [2:0]          in_bytes;
    logic                core_init;
    logic                core_next;
    logic [BLOCK_W-1:0]  core_block;
    logic                core_ready;
    logic [DIGEST_W-1:0] core_digest;
    logic                core_digest_valid;
    logic [DIGEST_W-1:0] digest;
    logic                digest_valid;
    logic                digest_ack;
    logic                busy;
    modport slave (
        input  in_valid, in_data, in_last, in_bytes, core_ready, core_digest, core_digest_valid, digest_ack,
        output in_ready, core_init, core_next, core_block, digest, digest_valid, busy
    );
    modport master (
        output in_valid, in_data, in_last, in_bytes, core_ready, core_digest, core_digest_valid, digest_ack,
        input  in_ready, core_init, core_next, core_block, digest, digest_valid, busy
    );
endinterface

// File: rtl/sha1_pad_word.sv
// sha1_pad_word: keeps the first i_bytes bytes of a last word and appends the 0x80 marker
// i_data: big-endian message word, i_bytes: valid bytes 0..4, o_word: merged word
// (for i_bytes=4 the word passes unchanged; the marker belongs to the next word)
module sha1_pad_word
    import sha1_pkg::*;
(
    input  logic [WORD_W-1:0] i_data,
    input  logic [2:0]        i_bytes,
    output logic [WORD_W-1:0] o_word
);
    logic [5:0] w_shift;
    assign w_shift = {i_bytes, 3'b000};
    assign o_word = (i_data & ~({WORD_W{1'b1}} >> w_shift)) | ({PAD_MARKER, 24'd0} >> w_shift);
endmodule

// File: rtl/sha1_block_feeder.sv
// sha1_block_feeder: packs message words into padded 512-bit SHA-1 blocks and collects the digest
// clk/reset: clock and synchronous active-high reset
// bus.in_*: word stream in; bus.core_*: block out to the core and its digest back;
// bus.digest*/busy: captured digest held for the consumer until acknowledged
module sha1_block_feeder
    import sha1_pkg::*;
(
    input logic clk,
    input logic reset,
    sha1_block_feeder_if.slave bus
);
    state_e r_state;
    logic [WORDS-1:0][WORD_W-1:0] r_buf;
    logic [3:0] r_idx;
    logic [63:0] r_len;
    logic r_sent, r_ended, r_lenblk, r_mark, r_skip, r_digest_valid;
    logic [DIGEST_W-1:0] r_digest;
    logic w_accept, w_pulse, w_b4;
    logic [4:0] w_mark_idx;
    logic [WORD_W-1:0] w_pad_word, w_pad_fill;

    sha1_pad_word u_pad (.i_data(bus.in_data), .i_bytes(bus.in_bytes), .o_word(w_pad_word));

    // word 0 sits in the top bits, so word index i lives in r_buf[15-i] (= ~i)
    assign bus.core_block = r_buf;
    assign bus.in_ready = r_state == IDLE || r_state == FILL;
    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_pulse = r_state == ISSUE && bus.core_ready;
    assign bus.core_init = w_pulse && !r_sent;
    assign bus.core_next = w_pulse && r_sent;
    assign bus.digest = r_digest;
    assign bus.digest_valid = r_digest_valid;
    assign bus.busy = r_state != IDLE;
    // a full last word pushes the marker into the following word
    assign w_b4 = bus.in_bytes[2];
    assign w_mark_idx = {1'b0, r_idx} + {4'd0, w_b4};
    assign w_pad_fill = r_mark ? {PAD_MARKER, 24'd0} :
                        (r_lenblk && r_idx == LEN_HI_IDX) ? r_len[63:32] :
                        (r_lenblk && r_idx == LEN_LO_IDX) ? r_len[31:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_buf <= '0;
            r_idx <= '0;
            r_len <= '0;
            r_sent <= 1'b0;
            r_ended <= 1'b0;
            r_lenblk <= 1'b0;
            r_mark <= 1'b0;
            r_skip <= 1'b0;
            r_digest <= '0;
            r_digest_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FILL: if (w_accept) begin
                    r_buf[~r_idx] <= bus.in_last ? w_pad_word : bus.in_data;
                    r_len <= r_len + (bus.in_last ? {58'd0, bus.in_bytes, 3'd0} : 64'd32);
                    r_idx <= r_idx + 4'd1;
                    if (bus.in_last) begin
                        r_ended <= 1'b1;
                        r_mark <= w_b4;
                        // length fits in this block only if the marker lands at or before word 13
                        r_lenblk <= (w_mark_idx <= 5'd13);
                        r_state <= r_idx == 4'd15 ? ISSUE : PAD;
                    end else begin
                        r_state <= r_idx == 4'd15 ? ISSUE : FILL;
                    end
                end
                PAD: begin
                    r_buf[~r_idx] <= w_pad_fill;
                    r_mark <= 1'b0;
                    r_idx <= r_idx + 4'd1;
                    if (r_idx == 4'd15) r_state <= ISSUE;
                end
                ISSUE: if (bus.core_ready) begin
                    r_sent <= 1'b1;
                    r_skip <= 1'b1;
                    r_state <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    // the core may still show ready on the cycle right after the pulse
                    r_skip <= 1'b0;
                    if (!r_skip && bus.core_ready) begin
                        if (r_lenblk) begin
                            if (bus.core_digest_valid) begin
                                r_digest <= bus.core_digest;
                                r_digest_valid <= 1'b1;
                                r_state <= DONE;
                            end
                        end else if (r_ended) begin
                            r_lenblk <= 1'b1;
                            r_state <= PAD;
                        end else begin
                            r_state <= FILL;
                        end
                    end
                end
                DONE: if (bus.digest_ack) begin
                    r_digest_valid <= 1'b0;
                    r_len <= '0;
                    r_sent <= 1'b0;
                    r_ended <= 1'b0;
                    r_lenblk <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha1_block_feeder.sv
// tb_sha1_block_feeder: table of messages plus hand sequences against a behavioural SHA-1 core
module tb_sha1_block_feeder;
    import sha1_pkg::*;

    localparam logic [159:0] IV = 160'h67452301efcdab8998badcfe10325476c3d2e1f0;
    localparam logic [159:0] DG_ABC = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
    localparam logic [159:0] DG_EMPTY = 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709;

    typedef struct {
        bit init;
        logic [BLOCK_W-1:0] blk;
    } blk_t;

    typedef struct {
        int len;
        int nblk;
        logic [31:0] w0;
        logic [31:0] w15;
        bit known;
        logic [159:0] dg;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sha1_block_feeder_if bus();
    sha1_block_feeder dut (.clk(clk), .reset(reset), .bus(bus));

    int n_pass = 0;
    int n_total = 0;
    int n_pulse = 0;
    blk_t exp_q[$];
    logic [159:0] h_model = '0;
    logic [BLOCK_W-1:0] last_blk = '0;
    int core_cnt = 0;
    logic core_dv = 1'b0;
    bit core_hold = 1'b0;
    vec_t vecs[9];

    assign bus.core_ready = !core_hold && core_cnt == 0;
    assign bus.core_digest = h_model;
    assign bus.core_digest_valid = core_dv;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w[80];
        logic [31:0] a, b, c, d, e, f, k, t;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 80; i++) begin
            t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
            w[i] = {t[30:0], t[31]};
        end
        {a, b, c, d, e} = h;
        for (int i = 0; i < 80; i++) begin
            if (i < 20) begin f = (b & c) | (~b & d); k = 32'h5a827999; end
            else if (i < 40) begin f = b ^ c ^ d; k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else begin f = b ^ c ^ d; k = 32'hca62c1d6; end
            t = {a[26:0], a[31:27]} + f + e + k + w[i];
            e = d;
            d = c;
            c = {b[1:0], b[31:2]};
            b = a;
            a = t;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    function automatic logic [7:0] msg_byte(input int len, input int i);
        return len == 3 ? 8'(8'h61 + i) : 8'(8'h10 + i);
    endfunction

    // core model plus block scoreboard
    always @(posedge clk) begin
        blk_t e;
        if (reset) begin
            core_cnt <= 0;
            core_dv <= 1'b0;
        end else if (bus.core_init || bus.core_next) begin
            n_pulse <= n_pulse + 1;
            h_model <= sha1_compress(bus.core_init ? IV : h_model, bus.core_block);
            core_cnt <= 4;
            core_dv <= 1'b0;
            last_blk <= bus.core_block;
            check("pulse_excl", bus.core_init & bus.core_next, 0);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL pulse_expected: got unexpected pulse want none");
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_init", bus.core_init, e.init);
                check("block", bus.core_block, e.blk);
            end
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_dv <= 1'b1;
        end
    end

    task automatic push_expected(input int len);
        logic [7:0] p[256];
        logic [63:0] bits;
        blk_t e;
        int nb;
        nb = (len + 8) / 64 + 1;
        bits = 64'(len) * 64'd8;
        for (int i = 0; i < 64 * nb; i++) p[i] = i < len ? msg_byte(len, i) : (i == len ? 8'h80 : 8'h00);
        for (int i = 0; i < 8; i++) p[64*nb-1-i] = bits[8*i +: 8];
        for (int b = 0; b < nb; b++) begin
            e.init = b == 0;
            for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = p[64*b+i];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_total++;
            $display("FAIL in_ready_timeout: got 0 want 1");
        end
        @(posedge clk);
    endtask

    task automatic drive_word(input int len, input int k, input int nw, input bit last);
        logic [31:0] d;
        for (int j = 0; j < 4; j++) d[31-8*j -: 8] = (4*k + j < len) ? msg_byte(len, 4*k + j) : 8'haa;
        bus.in_valid = 1'b1;
        bus.in_data = d;
        bus.in_last = last;
        bus.in_bytes = 3'(len - 4 * (nw - 1));
    endtask

    task automatic send_msg(input int len);
        int nw;
        nw = len == 0 ? 1 : (len + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            drive_word(len, k, nw, k == nw - 1);
            wait_ready();
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_digest();
        int n = 0;
        while (!bus.digest_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("digest_valid_seen", bus.digest_valid, 1);
    endtask

    task automatic ack_digest(input int delay, input logic [159:0] want);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("done_hold", {bus.digest_valid, bus.in_ready, bus.digest}, {1'b1, 1'b0, want});
        end
        bus.digest_ack = 1'b1;
        @(negedge clk);
        bus.digest_ack = 1'b0;
        check("back_to_idle", {bus.in_ready, bus.busy, bus.digest_valid}, 3'b100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BLOCK_W-1:0] snap;
        int p0;
        vecs[0] = '{3, 1, 32'h61626380, 32'h18, 1'b1, DG_ABC};
        vecs[1] = '{0, 1, 32'h80000000, 32'h0, 1'b1, DG_EMPTY};
        vecs[2] = '{56, 2, 32'h0, 32'h1c0, 1'b0, '0};
        vecs[3] = '{64, 2, 32'h80000000, 32'h200, 1'b0, '0};
        vecs[4] = '{55, 1, 32'h10111213, 32'h1b8, 1'b0, '0};
        vecs[5] = '{60, 2, 32'h0, 32'h1e0, 1'b0, '0};
        vecs[6] = '{57, 2, 32'h0, 32'h1c8, 1'b0, '0};
        vecs[7] = '{128, 3, 32'h80000000, 32'h400, 1'b0, '0};
        vecs[8] = '{5, 1, 32'h10111213, 32'h28, 1'b0, '0};
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        bus.in_bytes = '0;
        bus.digest_ack = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_state", {bus.in_ready, bus.core_init, bus.core_next, bus.digest_valid, bus.busy}, 5'b10000);
        check("reset_digest", bus.digest, 0);
        check("reset_block", bus.core_block, 0);

        for (int v = 0; v < 9; v++) begin
            p0 = n_pulse;
            push_expected(vecs[v].len);
            send_msg(vecs[v].len);
            wait_digest();
            check($sformatf("v%0d_blocks", v), n_pulse - p0, vecs[v].nblk);
            check($sformatf("v%0d_w0", v), last_blk[511:480], vecs[v].w0);
            check($sformatf("v%0d_w15", v), last_blk[31:0], vecs[v].w15);
            check($sformatf("v%0d_digest", v), bus.digest, vecs[v].known ? vecs[v].dg : h_model);
            check($sformatf("v%0d_queue_empty", v), exp_q.size(), 0);
            ack_digest(v % 3, bus.digest);
        end

        // core stalls in ISSUE, then a slow digest consumer
        core_hold = 1'b1;
        p0 = n_pulse;
        push_expected(3);
        send_msg(3);
        repeat (20) @(negedge clk);
        snap = bus.core_block;
        check("stall_no_pulse", n_pulse - p0, 0);
        check("stall_block_w0", snap[511:480], 32'h61626380);
        repeat (5) @(negedge clk);
        check("stall_block_stable", bus.core_block, snap);
        check("stall_still_no_pulse", n_pulse - p0, 0);
        core_hold = 1'b0;
        wait_digest();
        check("stall_pulses", n_pulse - p0, 1);
        check("stall_digest", bus.digest, DG_ABC);
        ack_digest(10, DG_ABC);

        // reset while word 7 of a block is offered
        p0 = n_pulse;
        for (int k = 0; k < 7; k++) begin
            drive_word(64, k, 16, 1'b0);
            wait_ready();
            @(negedge clk);
        end
        drive_word(64, 7, 16, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        check("midreset_state", {bus.in_ready, bus.core_init, bus.core_next, bus.digest_valid, bus.busy}, 5'b10000);
        check("midreset_digest", bus.digest, 0);
        check("midreset_block", bus.core_block, 0);
        repeat (30) @(negedge clk);
        check("midreset_no_pulse", n_pulse - p0, 0);
        push_expected(3);
        send_msg(3);
        wait_digest();
        check("after_reset_digest", bus.digest, DG_ABC);
        check("after_reset_pulses", n_pulse - p0, 1);
        ack_digest(0, DG_ABC);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sha1_block_feeder.md
SHA1_BLOCK_FEEDER -- requirements
Module: sha1_block_feeder

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  message word offered.
- in_ready  out  1  feeder accepts word this cycle.
- in_data  in  32  message word, big-endian: first byte in [31:24].
- in_last  in  1  word is the final word of the message.
- in_bytes  in  3  valid bytes in the last word, 0..4; ignored unless in_last.
- core_init  out  1  one-cycle pulse: first block of a message.
- core_next  out  1  one-cycle pulse: subsequent block.
- core_block  out  512  padded block; word 0 in [511:480].
- core_ready  in  1  SHA-1 core idle and able to take a block.
- core_digest  in  160  core result.
- core_digest_valid  in  1  core_digest is valid.
- digest  out  160  captured final digest.
- digest_valid  out  1  digest is held for the consumer.
- digest_ack  in  1  consumer has taken the digest.
- busy  out  1  a message is in progress or a digest is pending.

Function
REQ-002 A word SHALL transfer only on a cycle where in_valid and in_ready are both 1.
REQ-003 States SHALL be IDLE, FILL, PAD, ISSUE, WAIT_CORE and DONE.
REQ-004 in_ready SHALL be 1 only in IDLE and FILL; it SHALL be 0 in every other state.
REQ-005 The 16-word buffer SHALL write each accepted word at the current word index (0..15); IDLE moves to FILL on the first accepted word.
REQ-006 The 64-bit bit-length counter SHALL add 32 for each non-last word and 8*in_bytes for the last word; it wraps modulo 2^64.
REQ-007 An accepted non-last word at index 15 SHALL move the state to ISSUE with the block full; after that block is issued, filling resumes at index 0.
REQ-008 On the last word with b<4 bytes, bytes b..3 SHALL be replaced by 0x80 followed by zeros; for b=4, the word SHALL be kept and 0x80000000 SHALL go in the next word.
REQ-009 PAD SHALL zero-fill the remaining words at one word per cycle.
REQ-010 If the 0x80 marker word index is at most 13, PAD SHALL place length[63:32] in word 14 and length[31:0] in word 15, and the block is the final block.
REQ-011 If the 0x80 marker word index is 14 or 15, PAD SHALL zero the rest of the block and issue it; it SHALL then build an extra final block of zeros with the length in words 14 and 15.
REQ-012 In ISSUE the feeder SHALL pulse core_init for the first block of a message (core_next for later blocks) for exactly one cycle, and only when core_ready=1.
REQ-013 core_block SHALL stay stable from the pulse cycle until WAIT_CORE exits.
REQ-014 WAIT_CORE SHALL ignore core_ready on the cycle after the pulse, then wait for core_ready=1.
REQ-015 When WAIT_CORE exits, it SHALL return to FILL for a non-final block and PAD for a pending extra block.
REQ-016 After the final block, when core_ready and core_digest_valid are both 1, the feeder SHALL capture core_digest into digest, set digest_valid=1 and enter DONE.
REQ-017 In DONE, digest and digest_valid SHALL hold until digest_ack=1; the feeder then clears digest_valid, clears the length counter and enters IDLE on the next cycle.
REQ-018 A new message SHALL NOT be accepted before that return to IDLE.
REQ-019 core_init and core_next SHALL never be high together.
REQ-020 busy SHALL be 0 only in IDLE.

Reset
REQ-021 On reset the feeder SHALL enter IDLE, clear the word index, length counter and first-block flag, and hold in_ready=1, core_init=0, core_next=0, digest=0, digest_valid=0 and busy=0.
REQ-022 On reset the buffer and core_block SHALL be zeroed.
REQ-023 Reset mid-message SHALL discard the partial message with no further core pulse.

Structure
REQ-024 A shared package sha1_pkg SHALL hold the state enum and these constants: block width 512, digest width 160, word width 32, pad marker 0x80, and length words 14 and 15.
REQ-025 One sub-module sha1_pad_word SHALL combinationally merge a partial last word with the 0x80 marker.

Verification
REQ-026 "abc" (one word 0x61626300, in_bytes=3) -> init pulse; block word0=0x61626380, word15=0x00000018; with the behavioural core model, digest=a9993e364706816aba3e25717850c26c9cd0d89d.
REQ-027 Empty message (in_bytes=0) -> block word0=0x80000000, all other words 0; digest=da39a3ee5e6b4b0d3255bfef95601890afd80709.
REQ-028 56-byte message -> init then next; second block words 0..13 zero, word15=0x000001C0.
REQ-029 64-byte message (last word in_bytes=4) -> two blocks; second block word0=0x80000000, word15=0x00000200.
REQ-030 core_ready held low 5 cycles in ISSUE -> no pulse until core_ready=1, core_block unchanged; digest_ack delayed 10 cycles -> digest_valid held and in_ready=0 throughout.
REQ-031 Reset asserted at word 7 of a block -> all REQ-021 values next cycle; a following "abc" message produces the REQ-026 result.
